// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing with mid-bit sampling,
// a one-entry holding register with valid/read handshake, and sticky error flags.
module uart_rx #(
  parameter int DBIT_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  s_tick,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DBIT_WIDTH-1:0] data_out,
  output logic                  rx_valid,
  output logic                  rx_done_tick,
  output logic                  frame_err,
  output logic                  overrun_err
);

  localparam int CNT_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW      = $clog2(CNT_MAX);
  localparam int BW      = $clog2(DBIT_WIDTH) + 1;

  localparam logic [SW-1:0] START_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] DATA_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_LAST  = SW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DBIT_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_next;
  logic [SW-1:0]         s_cnt, s_cnt_next;
  logic [BW-1:0]         bit_cnt, bit_cnt_next;
  logic [DBIT_WIDTH-1:0] shift_reg, shift_next;
  logic                  sync1, rx_sync, rx_prev;
  logic                  done;

  // Synchronizer resets to the idle-high level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_sync <= sync1;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      s_cnt     <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      s_cnt     <= s_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next   = state;
    s_cnt_next   = s_cnt;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        // Edge (not level) detection keeps a held-low break from re-triggering.
        if (rx_prev && !rx_sync) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == START_LAST) begin
            if (!rx_sync) begin
              state_next   = DATA;
              s_cnt_next   = '0;
              bit_cnt_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == DATA_LAST) begin
            s_cnt_next = '0;
            shift_next = {rx_sync, shift_reg[DBIT_WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) state_next = STOP;
            else bit_cnt_next = bit_cnt + 1'b1;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_LAST) begin
            state_next = IDLE;
            s_cnt_next = '0;
            done       = 1'b1;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A read on the completion clk frees the slot, so the new word is not an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out     <= '0;
      rx_valid     <= 1'b0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      rx_done_tick <= done;
      if (done && rx_sync) begin
        data_out <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rd_en && rx_valid) begin
        rx_valid <= 1'b0;
      end
      if (done && !rx_sync) frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (done && rx_sync && rx_valid && !rd_en) overrun_err <= 1'b1;
      else if (err_clr) overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner
// sequences and randomized frames checked against a transaction-level model.
module tb_uart_rx;

  localparam int BIT_CLKS   = 64;   // 16 s_ticks per bit, one s_tick every 4 clk
  localparam int DONE_TICKS = 152;  // 8 (half start) + 8*16 (data) + 16 (stop)

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       rx_valid, rx_done_tick, frame_err, overrun_err;

  int pass_count = 0;
  int check_count = 0;
  int done_count = 0;
  int exp_done = 0;
  int tick_div = 0;

  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_oerr;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    bit         rd;
    bit         clr;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
    logic       exp_oerr;
  } vec_t;

  vec_t vecs[7];

  uart_rx #(.DBIT_WIDTH(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .s_tick(s_tick), .rd_en(rd_en), .err_clr(err_clr),
    .data_out(data_out), .rx_valid(rx_valid), .rx_done_tick(rx_done_tick),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_div == 3) begin
      tick_div = 0;
      s_tick   = 1'b1;
    end else begin
      tick_div = tick_div + 1;
      s_tick   = 1'b0;
    end
  end

  always @(negedge clk) if (rx_done_tick) done_count = done_count + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic checkModel(input string name);
    checkOutput({name, " data_out"}, 32'(data_out), 32'(m_data));
    checkOutput({name, " rx_valid"}, 32'(rx_valid), 32'(m_valid));
    checkOutput({name, " frame_err"}, 32'(frame_err), 32'(m_ferr));
    checkOutput({name, " overrun_err"}, 32'(overrun_err), 32'(m_oerr));
    checkOutput({name, " done ticks"}, 32'(done_count), 32'(exp_done));
  endtask

  // Transmit one frame, optionally holding the line low afterwards, then idle one bit time.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int low_after_bits);
    @(negedge clk) rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    if (low_after_bits > 0) begin
      rx = 1'b0;
      repeat (BIT_CLKS * low_after_bits) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Strobe rd_en (use_rd) or err_clr on the clk where the stop bit is sampled:
  // 2 sync clks + 1 clk to leave idle, then the DONE_TICKS-th s_tick.
  task automatic pulseOnCompletion(input bit use_rd);
    int cnt;
    cnt = 0;
    @(negedge rx);
    repeat (3) @(posedge clk);
    for (int guard = 0; guard < 3000 && cnt < DONE_TICKS; guard++) begin
      @(negedge clk);
      #1;
      if (s_tick) begin
        cnt++;
        if (cnt == DONE_TICKS) begin
          if (use_rd) rd_en = 1'b1;
          else err_clr = 1'b1;
        end
      end
    end
    if (cnt != DONE_TICKS) checkOutput("completion tick search", 32'(cnt), 32'(DONE_TICKS));
    @(negedge clk);
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic modelFrame(input logic [7:0] data, input logic stop, input bit rd, input bit clr);
    logic set_f, set_o;
    set_f = !stop;
    set_o = stop && m_valid && !rd;
    if (clr) begin m_ferr = 1'b0; m_oerr = 1'b0; end
    if (set_f) m_ferr = 1'b1;
    if (set_o) m_oerr = 1'b1;
    if (stop) begin m_data = data; m_valid = 1'b1; end
    else if (rd) m_valid = 1'b0;
    exp_done++;
  endtask

  task automatic popWord();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic clearErrors();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    m_ferr = 1'b0;
    m_oerr = 1'b0;
  endtask

  task automatic modelReset();
    m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    modelReset();
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h7E, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0};

    modelReset();
    repeat (4) @(negedge clk);
    checkModel("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven frames: expectations are hand-written constants.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].data, vecs[i].stop, 0);
      modelFrame(vecs[i].data, vecs[i].stop, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d done ticks", i), 32'(done_count), 32'(exp_done));
      if (vecs[i].rd) popWord();
      if (vecs[i].clr) clearErrors();
      checkOutput($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      checkOutput($sformatf("vec%0d overrun_err", i), 32'(overrun_err), 32'(vecs[i].exp_oerr));
    end

    // Short low pulse (5 s_ticks) must be rejected as a glitch.
    @(negedge clk) rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT_CLKS) @(negedge clk);
    checkModel("glitch");
    popWord();
    applyStimulus(8'h3C, 1'b1, 0);
    modelFrame(8'h3C, 1'b1, 1'b0, 1'b0);
    checkModel("after glitch");

    // Framing error followed by a 40-bit break: exactly one tick.
    resetDut();
    applyStimulus(8'h3C, 1'b0, 40);
    modelFrame(8'h3C, 1'b0, 1'b0, 1'b0);
    checkModel("break");
    applyStimulus(8'h81, 1'b1, 0);
    modelFrame(8'h81, 1'b1, 1'b0, 1'b0);
    checkModel("after break");
    clearErrors();
    checkModel("err_clr");

    // Overrun, then a read on the completion clk which must avoid it.
    resetDut();
    applyStimulus(8'h11, 1'b1, 0);
    modelFrame(8'h11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b1, 0);
    modelFrame(8'h22, 1'b1, 1'b0, 1'b0);
    checkModel("overrun");
    clearErrors();
    popWord();
    checkOutput("data held after pop", 32'(data_out), 32'h22);
    applyStimulus(8'h11, 1'b1, 0);
    modelFrame(8'h11, 1'b1, 1'b0, 1'b0);
    fork
      applyStimulus(8'h22, 1'b1, 0);
      pulseOnCompletion(1'b1);
    join
    modelFrame(8'h22, 1'b1, 1'b1, 1'b0);
    checkModel("rd on completion");

    // err_clr coinciding with a new framing error: the set wins, overrun still clears.
    applyStimulus(8'h55, 1'b1, 0);
    modelFrame(8'h55, 1'b1, 1'b0, 1'b0);
    fork
      applyStimulus(8'h44, 1'b0, 0);
      pulseOnCompletion(1'b0);
    join
    modelFrame(8'h44, 1'b0, 1'b0, 1'b1);
    checkModel("clr vs set");

    // Reset during data bit 3 (a high bit; the rest of 0xFA is high too).
    fork
      applyStimulus(8'hFA, 1'b1, 0);
      begin
        @(negedge rx);
        repeat (4 * BIT_CLKS + 32) @(negedge clk);
        rst = 1'b0;
        #1;
        modelReset();
        checkModel("async reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
      end
    join
    checkModel("aborted frame");
    applyStimulus(8'h5A, 1'b1, 0);
    modelFrame(8'h5A, 1'b1, 1'b0, 1'b0);
    checkModel("after abort");

    // Randomized frames against the model.
    for (int n = 0; n < 48; n++) begin
      logic [7:0] d;
      logic       stop;
      bit         rd_done, rd_after, clr_after;
      d         = 8'($urandom);
      stop      = ($urandom_range(0, 7) != 0);
      rd_done   = ($urandom_range(0, 3) == 0);
      rd_after  = ($urandom_range(0, 1) == 0);
      clr_after = ($urandom_range(0, 3) == 0);
      if (rd_done) begin
        fork
          applyStimulus(d, stop, 0);
          pulseOnCompletion(1'b1);
        join
      end else begin
        applyStimulus(d, stop, 0);
      end
      modelFrame(d, stop, rd_done, 1'b0);
      if (rd_after) popWord();
      if (clr_after) clearErrors();
      checkModel($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
